// File: rtl/if_pc_ctrl_pkg.sv
// Shared types and constants for the fetch sequencer.
// IF_PC_CTRL_BPRED_EN enables the static branch predecode opcodes.
package if_pc_ctrl_pkg;

    localparam int PC_WIDTH    = 32;
    localparam int INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 32'h0000_0013;

`ifdef IF_PC_CTRL_BPRED_EN
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
`endif

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4
    } ifc_state_e;

    function automatic logic pc_aligned(input logic [1:0] pc_lsb);
        return pc_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/if_pc_ctrl_predecode.sv
// Static predecode of a fetched word: jal and backward bxx are predicted taken.
// Only compiled and instanced when IF_PC_CTRL_BPRED_EN is defined.
`ifdef IF_PC_CTRL_BPRED_EN
module if_predecode
    import if_pc_ctrl_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic [PC_WIDTH-1:0]    pc_i,
    output logic                   taken_o,
    output logic [PC_WIDTH-1:0]    target_o
);

    logic [PC_WIDTH-1:0] j_imm;
    logic [PC_WIDTH-1:0] b_imm;
    logic                is_jal;
    logic                is_bxx;

    assign j_imm = {{(PC_WIDTH-20){instr_i[31]}}, instr_i[19:12],
                    instr_i[20], instr_i[30:21], 1'b0};
    assign b_imm = {{(PC_WIDTH-12){instr_i[31]}}, instr_i[7],
                    instr_i[30:25], instr_i[11:8], 1'b0};

    assign is_jal = instr_i[6:0] == OPC_JAL;
    assign is_bxx = (instr_i[6:0] == OPC_BRANCH) && instr_i[31];

    assign taken_o = is_jal | is_bxx;

    always_comb begin
        target_o = pc_i + PC_WIDTH'(4);
        unique case (1'b1)
            is_jal:  target_o = pc_i + j_imm;
            is_bxx:  target_o = pc_i + b_imm;
            default: target_o = pc_i + PC_WIDTH'(4);
        endcase
    end

endmodule
`endif

// File: rtl/if_pc_ctrl.sv
// Fetch sequencer: owns the PC, issues one bus request at a time, holds the word for decode.
// IF_PC_CTRL_BPRED_EN adds static predecode of the latched word.
module if_pc_ctrl
    import if_pc_ctrl_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    output logic                   ifb_req_valid_o,
    output logic [PC_WIDTH-1:0]    ifb_req_addr_o,
    input  logic                   ifb_req_ready_i,
    input  logic                   ifb_rsp_valid_i,
    input  logic [INSTR_WIDTH-1:0] ifb_rsp_instr_i,
    input  logic                   ifb_rsp_err_i,
    input  logic                   redirect_valid_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    output logic                   id_valid_o,
    input  logic                   id_ready_i,
    output logic [PC_WIDTH-1:0]    id_pc_o,
    output logic [INSTR_WIDTH-1:0] id_instr_o,
    output logic                   id_prdt_taken_o,
    output logic                   id_pc_misalign_o,
    output logic                   id_bus_err_o
);

    ifc_state_e             state_q;
    logic [PC_WIDTH-1:0]    pc_q;
    logic [PC_WIDTH-1:0]    pc_nxt_q;
    logic                   req_valid_q;
    logic                   id_valid_q;
    logic [PC_WIDTH-1:0]    id_pc_q;
    logic [INSTR_WIDTH-1:0] id_instr_q;
    logic                   id_taken_q;
    logic                   id_misalign_q;
    logic                   id_bus_err_q;

    logic                   req_fire;
    logic                   owed;
    logic [PC_WIDTH-1:0]    pc_plus4;
    logic                   bp_taken;
    logic [PC_WIDTH-1:0]    bp_target;

    assign pc_plus4 = pc_q + PC_WIDTH'(4);
    assign req_fire = req_valid_q & ifb_req_ready_i;

    // A response is still owed after this edge unless it arrives now.
    assign owed = (((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && !ifb_rsp_valid_i)
                || ((state_q == ST_REQ) && req_fire);

`ifdef IF_PC_CTRL_BPRED_EN
    if_predecode u_predecode (
        .instr_i  (ifb_rsp_instr_i),
        .pc_i     (pc_q),
        .taken_o  (bp_taken),
        .target_o (bp_target)
    );
`else
    assign bp_taken  = 1'b0;
    assign bp_target = pc_plus4;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            pc_nxt_q      <= '0;
            req_valid_q   <= 1'b0;
            id_valid_q    <= 1'b0;
            id_pc_q       <= '0;
            id_instr_q    <= '0;
            id_taken_q    <= 1'b0;
            id_misalign_q <= 1'b0;
            id_bus_err_q  <= 1'b0;
        end else if (redirect_valid_i && (state_q != ST_BOOT)) begin
            pc_q       <= redirect_pc_i;
            id_valid_q <= 1'b0;
            if (owed) begin
                state_q     <= ST_DRAIN;
                req_valid_q <= 1'b0;
            end else begin
                state_q     <= ST_REQ;
                req_valid_q <= pc_aligned(redirect_pc_i[1:0]);
            end
        end else begin
            unique case (state_q)
                ST_BOOT: begin
                    state_q     <= ST_REQ;
                    req_valid_q <= pc_aligned(pc_q[1:0]);
                end
                ST_REQ: begin
                    if (!pc_aligned(pc_q[1:0])) begin
                        state_q       <= ST_HOLD;
                        id_valid_q    <= 1'b1;
                        id_pc_q       <= pc_q;
                        id_instr_q    <= INSTR_NOP;
                        id_taken_q    <= 1'b0;
                        id_misalign_q <= 1'b1;
                        id_bus_err_q  <= 1'b0;
                        pc_nxt_q      <= pc_plus4;
                    end else if (req_fire) begin
                        state_q     <= ST_WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (ifb_rsp_valid_i) begin
                        state_q       <= ST_HOLD;
                        id_valid_q    <= 1'b1;
                        id_pc_q       <= pc_q;
                        id_misalign_q <= 1'b0;
                        id_bus_err_q  <= ifb_rsp_err_i;
                        id_instr_q    <= ifb_rsp_err_i ? INSTR_NOP : ifb_rsp_instr_i;
                        id_taken_q    <= !ifb_rsp_err_i && bp_taken;
                        pc_nxt_q      <= (!ifb_rsp_err_i && bp_taken) ? bp_target : pc_plus4;
                    end
                end
                ST_HOLD: begin
                    if (id_ready_i) begin
                        state_q     <= ST_REQ;
                        id_valid_q  <= 1'b0;
                        pc_q        <= pc_nxt_q;
                        req_valid_q <= pc_aligned(pc_nxt_q[1:0]);
                    end
                end
                ST_DRAIN: begin
                    if (ifb_rsp_valid_i) begin
                        state_q     <= ST_REQ;
                        req_valid_q <= pc_aligned(pc_q[1:0]);
                    end
                end
                default: begin
                    state_q     <= ST_BOOT;
                    req_valid_q <= 1'b0;
                    id_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ifb_req_valid_o  = req_valid_q;
    assign ifb_req_addr_o   = pc_q;
    assign id_valid_o       = id_valid_q;
    assign id_pc_o          = id_pc_q;
    assign id_instr_o       = id_instr_q;
    assign id_prdt_taken_o  = id_taken_q;
    assign id_pc_misalign_o = id_misalign_q;
    assign id_bus_err_o     = id_bus_err_q;

endmodule

// File: tb/tb_if_pc_ctrl.sv
// Random bus/decode/redirect traffic checked against a program-order fetch model.
// Build with IF_PC_CTRL_BPRED_EN to also check static prediction.
module tb_if_pc_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          NCYC   = 5000;
`ifdef IF_PC_CTRL_BPRED_EN
    localparam bit BPRED = 1'b1;
`else
    localparam bit BPRED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_instr = '0;
    logic        rsp_err = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_taken;
    logic        id_mis;
    logic        id_err;

    if_pc_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .ifb_req_valid_o  (req_valid),
        .ifb_req_addr_o   (req_addr),
        .ifb_req_ready_i  (req_ready),
        .ifb_rsp_valid_i  (rsp_valid),
        .ifb_rsp_instr_i  (rsp_instr),
        .ifb_rsp_err_i    (rsp_err),
        .redirect_valid_i (redir),
        .redirect_pc_i    (redir_pc),
        .id_valid_o       (id_valid),
        .id_ready_i       (id_ready),
        .id_pc_o          (id_pc),
        .id_instr_o       (id_instr),
        .id_prdt_taken_o  (id_taken),
        .id_pc_misalign_o (id_mis),
        .id_bus_err_o     (id_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction memory: a fixed pseudo-random word per address, salted with jal/bxx.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        case ((a >> 2) % 5)
            0: w[6:0] = 7'b1100011;
            1: w[6:0] = 7'b1101111;
            default: ;
        endcase
        return w;
    endfunction

    function automatic logic bus_err_at(input logic [31:0] a);
        return ((a >> 2) % 7) == 3;
    endfunction

    // {taken, next pc} for a cleanly fetched word.
    function automatic logic [32:0] predict(input logic [31:0] pc, input logic [31:0] w);
        logic signed [20:0] j;
        logic signed [12:0] b;
        j = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        b = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        if (BPRED && w[6:0] == 7'b1101111) return {1'b1, pc + 32'(j)};
        if (BPRED && w[6:0] == 7'b1100011 && b < 0) return {1'b1, pc + 32'(b)};
        return {1'b0, pc + 32'd4};
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0100;
            1: return 32'h0000_0102;
            2: return 32'h0000_0040;
            3: return 32'hFFFF_FFFC;
            4: return 32'h0000_0020;
            default: return {$urandom_range(0, 32'h3FFF), 2'b00};
        endcase
    endfunction

    task automatic reset_checks();
        check("rst_ctl", 64'({req_valid, id_valid, id_mis, id_err, id_taken}), 64'd0);
        check("rst_data", {id_pc, id_instr}, 64'd0);
        check("rst_addr", 64'(req_addr), 64'(RST_PC));
    endtask

    logic [31:0] exp_pc;
    logic [31:0] pend_addr[$];
    int          pend_dly[$];
    int          since_rst;
    int          idle;
    int          n_deliv;

    initial begin
        logic        mis;
        logic        err;
        logic [31:0] w;
        logic [32:0] pr;

        exp_pc    = RST_PC;
        since_rst = 0;
        idle      = 0;
        n_deliv   = 0;
        repeat (3) @(negedge clk);
        reset_checks();
        rst_n = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            since_rst++;

            if (cyc == NCYC / 2) begin
                rst_n     = 1'b0;
                redir     = 1'b0;
                rsp_valid = 1'b0;
                req_ready = 1'b0;
                id_ready  = 1'b0;
                #1;
                reset_checks();
                pend_addr.delete();
                pend_dly.delete();
                exp_pc    = RST_PC;
                idle      = 0;
                since_rst = 0;
                @(negedge clk);
                rst_n = 1'b1;
                continue;
            end

            mis = exp_pc[1:0] != 2'b00;
            err = !mis && bus_err_at(exp_pc);
            w   = mem_word(exp_pc);
            pr  = (mis || err) ? {1'b0, exp_pc + 32'd4} : predict(exp_pc, w);

            if (id_valid) begin
                check("id_pc", 64'(id_pc), 64'(exp_pc));
                check("id_instr", 64'(id_instr), 64'((mis || err) ? NOP : w));
                check("id_flags", 64'({id_mis, id_err, id_taken}), 64'({mis, err, pr[32]}));
            end
            if (req_valid) begin
                check("req_addr", 64'(req_addr), 64'(exp_pc));
                check("req_single", 64'(pend_addr.size()), 64'd0);
            end

            rsp_valid = 1'b0;
            rsp_instr = $urandom;
            rsp_err   = 1'($urandom_range(0, 1));
            if (pend_addr.size() > 0) begin
                if (pend_dly[0] == 0) begin
                    rsp_valid = 1'b1;
                    rsp_instr = mem_word(pend_addr[0]);
                    rsp_err   = bus_err_at(pend_addr[0]);
                    void'(pend_addr.pop_front());
                    void'(pend_dly.pop_front());
                end else begin
                    pend_dly[0] = pend_dly[0] - 1;
                end
            end

            req_ready = $urandom_range(0, 9) < 7;
            id_ready  = $urandom_range(0, 9) < 7;
            redir     = (since_rst >= 2) && ($urandom_range(0, 15) == 0);
            redir_pc  = redir ? pick_target() : 32'($urandom);

            if (redir) begin
                exp_pc = redir_pc;
                idle   = 0;
            end else if (id_valid && id_ready) begin
                exp_pc = pr[31:0];
                idle   = 0;
                n_deliv++;
            end else begin
                idle++;
            end

            if (req_valid && req_ready) begin
                pend_addr.push_back(req_addr);
                pend_dly.push_back($urandom_range(0, 3));
            end

            if (idle > 80) begin
                check("watchdog", 64'(idle), 64'd0);
                break;
            end
        end

        check("progress", 64'(n_deliv > 200), 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
